// File: rtl/vcxo_mcu_link.sv
// MCU command/status port for the VCXO discipline loop: byte-wide command FSM,
// clamped correction register, coherent status readback and a lock detector.
module vcxo_mcu_link #(
    parameter int          CORR_LIMIT  = 100,
    parameter int          LOCK_TOL    = 20,
    parameter int unsigned LOCK_CYCLES = 1228800
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic [23:0] freq_error_in,
    input  logic [23:0] pwm_in,
    input  logic        cmd_frame_in,
    input  logic [7:0]  cmd_data_in,
    input  logic        cmd_valid_in,
    output logic [7:0]  resp_data,
    output logic        resp_valid,
    output logic [7:0]  VCXO_correction,
    output logic        locked,
    output logic        cmd_error
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_OPCODE    = 3'd1;
    localparam logic [2:0] ST_WR_CORR   = 3'd2;
    localparam logic [2:0] ST_RD_STATUS = 3'd3;
    localparam logic [2:0] ST_RD_LOCK   = 3'd4;
    localparam logic [2:0] ST_DRAIN     = 3'd5;

    localparam logic [7:0] OP_WR_CORR   = 8'hA0;
    localparam logic [7:0] OP_RD_STATUS = 8'hA1;
    localparam logic [7:0] OP_RD_LOCK   = 8'hA2;
    localparam logic [7:0] OP_CLR_ERR   = 8'hA3;

    localparam logic signed [7:0]  CORR_POS = 8'(CORR_LIMIT);
    localparam logic signed [7:0]  CORR_NEG = 8'(-CORR_LIMIT);
    localparam logic signed [23:0] TOL_POS  = 24'(LOCK_TOL);
    localparam logic signed [23:0] TOL_NEG  = 24'(-LOCK_TOL);
    localparam logic [31:0]        LOCK_MAX = 32'(LOCK_CYCLES);

    logic [2:0]  r_state;
    logic [2:0]  r_idx;
    logic [47:0] r_snap;
    logic [31:0] r_lock_cnt;

    logic              w_accept;
    logic              w_opcode_hit;
    logic signed [7:0] w_data_s;
    logic signed [7:0] w_corr;
    logic              w_in_tol;

    assign w_accept     = cmd_valid_in && cmd_frame_in;
    // A byte arriving on the very cycle the frame rises is still the opcode.
    assign w_opcode_hit = w_accept && (r_state == ST_IDLE || r_state == ST_OPCODE);
    assign w_data_s     = cmd_data_in;
    assign w_corr       = (w_data_s > CORR_POS) ? CORR_POS :
                          (w_data_s < CORR_NEG) ? CORR_NEG : w_data_s;
    // Signed window compare rather than abs(), so -2^23 cannot wrap positive.
    assign w_in_tol     = ($signed(freq_error_in) >= TOL_NEG) &&
                          ($signed(freq_error_in) <= TOL_POS);

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            r_state         <= ST_IDLE;
            r_idx           <= 3'd0;
            r_snap          <= 48'd0;
            r_lock_cnt      <= 32'd0;
            resp_data       <= 8'd0;
            resp_valid      <= 1'b0;
            VCXO_correction <= 8'd0;
            locked          <= 1'b0;
            cmd_error       <= 1'b0;
        end else begin
            resp_valid <= 1'b0;

            if (w_in_tol) begin
                if (r_lock_cnt != LOCK_MAX) begin
                    r_lock_cnt <= r_lock_cnt + 32'd1;
                end
                locked <= (r_lock_cnt == LOCK_MAX);
            end else begin
                r_lock_cnt <= 32'd0;
                locked     <= 1'b0;
            end

            if (!cmd_frame_in) begin
                r_state <= ST_IDLE;
            end else if (w_opcode_hit) begin
                case (cmd_data_in)
                    OP_WR_CORR: r_state <= ST_WR_CORR;
                    OP_RD_STATUS: begin
                        r_state <= ST_RD_STATUS;
                        r_snap  <= {freq_error_in, pwm_in};
                        r_idx   <= 3'd0;
                    end
                    OP_RD_LOCK: r_state <= ST_RD_LOCK;
                    OP_CLR_ERR: begin
                        r_state   <= ST_DRAIN;
                        cmd_error <= 1'b0;
                    end
                    default: begin
                        r_state   <= ST_DRAIN;
                        cmd_error <= 1'b1;
                    end
                endcase
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_OPCODE;
                    ST_WR_CORR: begin
                        if (w_accept) begin
                            VCXO_correction <= w_corr;
                            r_state         <= ST_DRAIN;
                        end
                    end
                    ST_RD_STATUS: begin
                        if (w_accept) begin
                            // Snapshot is shifted out MSB-first: freq_error then pwm.
                            resp_data  <= r_snap[47:40];
                            resp_valid <= 1'b1;
                            r_snap     <= {r_snap[39:0], 8'd0};
                            r_idx      <= r_idx + 3'd1;
                            if (r_idx == 3'd5) begin
                                r_state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_RD_LOCK: begin
                        if (w_accept) begin
                            resp_data  <= {6'b0, cmd_error, locked};
                            resp_valid <= 1'b1;
                            r_state    <= ST_DRAIN;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vcxo_mcu_link.sv
// Self-checking bench for vcxo_mcu_link: write table, status/lock reads via a
// response scoreboard, error flag, frame boundaries, lock detector and reset.
module tb_vcxo_mcu_link;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] freq_error;
    logic [23:0] pwm;
    logic        frame;
    logic [7:0]  cmd_data;
    logic        cmd_valid;
    logic [7:0]  resp_data;
    logic        resp_valid;
    logic [7:0]  corr;
    logic        locked;
    logic        cmd_error;

    vcxo_mcu_link #(
        .CORR_LIMIT (100),
        .LOCK_TOL   (20),
        .LOCK_CYCLES(16)
    ) dut (
        .clk_in         (clk),
        .reset_n_in     (reset_n),
        .freq_error_in  (freq_error),
        .pwm_in         (pwm),
        .cmd_frame_in   (frame),
        .cmd_data_in    (cmd_data),
        .cmd_valid_in   (cmd_valid),
        .resp_data      (resp_data),
        .resp_valid     (resp_valid),
        .VCXO_correction(corr),
        .locked         (locked),
        .cmd_error      (cmd_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_corr;
    } wr_vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cmd_data  = b;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic dummy_exp(input logic [7:0] exp);
        sb_t e;
        e.data = exp;
        e.cyc  = cyc + 1;
        sb.push_back(e);
        send_byte(8'h00);
    endtask

    task automatic frame_begin();
        frame = 1'b1;
        tick();
    endtask

    task automatic frame_end();
        frame = 1'b0;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " corr"}, 32'(corr), 32'd0);
        chk({tag, " locked"}, 32'(locked), 32'd0);
        chk({tag, " cmd_error"}, 32'(cmd_error), 32'd0);
        chk({tag, " resp_data"}, 32'(resp_data), 32'd0);
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic reset_with_traffic();
        reset_n = 1'b0;
        frame   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cmd_data  = 8'hA1;
            cmd_valid = (i == 0);
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        wr_vec_t wr_tab[5];
        wr_tab[0] = '{din: 8'h7F, exp_corr: 8'd100};
        wr_tab[1] = '{din: 8'h9C, exp_corr: 8'h9C};
        wr_tab[2] = '{din: 8'h80, exp_corr: 8'h9C};
        wr_tab[3] = '{din: 8'h65, exp_corr: 8'd100};
        wr_tab[4] = '{din: 8'h05, exp_corr: 8'h05};

        reset_n = 1'b0; frame = 1'b0; cmd_data = 8'h00; cmd_valid = 1'b0;
        freq_error = 24'd1000; pwm = 24'd0;

        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    while (sb.size() > 0 && sb[0].cyc < cyc) begin
                        n_cmp++; n_bad++;
                        $display("FAIL resp_missing: got no resp_valid at cycle %0d, expected byte %02h",
                                 sb[0].cyc, sb[0].data);
                        void'(sb.pop_front());
                    end
                    if (resp_valid === 1'b1) begin
                        if (sb.size() == 0) begin
                            n_cmp++; n_bad++;
                            $display("FAIL resp_unexpected: got resp_valid data %02h at cycle %0d, expected none",
                                     resp_data, cyc);
                        end else begin
                            sb_t e;
                            e = sb.pop_front();
                            $display("resp byte %02h at cycle %0d", resp_data, cyc);
                            chk("resp_data", 32'(resp_data), 32'(e.data));
                            chk("resp_latency", 32'(cyc), 32'(e.cyc));
                        end
                    end
                end
            end
            begin : watchdog
                #2000000;
                $display("FAIL watchdog: got timeout, expected completion");
                $fatal(1, "timeout");
            end
        join_none

        // Power-up reset with a frame active and strobes toggling.
        reset_with_traffic();
        chk_all_zero("reset0");
        reset_n = 1'b1; frame = 1'b0;
        tick();

        // Table-driven correction writes including clamp boundaries.
        foreach (wr_tab[i]) begin
            frame_begin();
            send_byte(8'hA0);
            send_byte(wr_tab[i].din);
            $display("write %02h -> corr %02h", wr_tab[i].din, corr);
            chk("wr_corr", 32'(corr), 32'(wr_tab[i].exp_corr));
            frame_end();
        end
        frame_begin();
        send_byte(8'hA0);
        frame_end();
        tick();
        chk("wr_dropped", 32'(corr), 32'h05);

        // Coherent status read; inputs move right after the opcode strobe.
        freq_error = 24'hFFFFFD; pwm = 24'h0000FA;
        frame_begin();
        send_byte(8'hA1);
        freq_error = 24'h123456; pwm = 24'h654321;
        dummy_exp(8'hFF); dummy_exp(8'hFF); dummy_exp(8'hFD);
        dummy_exp(8'h00); dummy_exp(8'h00); dummy_exp(8'hFA);
        send_byte(8'h00);
        tick();
        frame_end();

        // Frame drops after two status bytes; next frame must decode an opcode.
        freq_error = 24'h00ABCD; pwm = 24'h00EF01;
        frame_begin();
        send_byte(8'hA1);
        dummy_exp(8'h00); dummy_exp(8'hAB);
        frame_end();
        frame_begin();
        send_byte(8'hA2);
        dummy_exp(8'h00);
        frame_end();

        // Error path: unknown opcode, ignored A3 in DRAIN, readback, clear.
        freq_error = 24'd1000;
        frame_begin();
        send_byte(8'h55);
        chk("err_set", 32'(cmd_error), 32'd1);
        send_byte(8'hA3);
        chk("err_drain_ignored", 32'(cmd_error), 32'd1);
        frame_end();
        frame_begin();
        send_byte(8'hA2);
        dummy_exp(8'h02);
        frame_end();
        frame_begin();
        send_byte(8'hA3);
        chk("err_clear", 32'(cmd_error), 32'd0);
        frame_end();

        // Strobe with frame low, and strobe coincident with frame fall.
        cmd_data = 8'h55; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("strobe_frame_low", 32'(cmd_error), 32'd0);
        frame_begin();
        frame = 1'b0;
        send_byte(8'h55);
        chk("strobe_at_fall_op", 32'(cmd_error), 32'd0);
        frame_begin();
        send_byte(8'hA0);
        frame = 1'b0;
        send_byte(8'h10);
        chk("strobe_at_fall_data", 32'(corr), 32'h05);

        // Lock detector: boundary tolerance both signs.
        tick();
        freq_error = 24'd20;
        for (int i = 0; i < 16; i++) tick();
        chk("lock_pos_early", 32'(locked), 32'd0);
        tick();
        chk("lock_pos", 32'(locked), 32'd1);
        frame_begin();
        send_byte(8'hA2);
        dummy_exp(8'h01);
        frame_end();
        freq_error = 24'd21;
        tick();
        chk("lock_drop", 32'(locked), 32'd0);
        freq_error = 24'hFFFFEC;
        for (int i = 0; i < 16; i++) tick();
        chk("lock_neg_early", 32'(locked), 32'd0);
        tick();
        chk("lock_neg", 32'(locked), 32'd1);

        // Mid-run reset clears everything; next frame decodes from OPCODE.
        reset_with_traffic();
        chk_all_zero("reset1");
        reset_n = 1'b1; frame = 1'b0; freq_error = 24'd1000;
        tick();
        frame_begin();
        send_byte(8'hA0);
        send_byte(8'h10);
        chk("post_reset_wr", 32'(corr), 32'h10);
        frame_end();

        for (int i = 0; i < 4; i++) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vcxo_mcu_link.md
Name: vcxo_mcu_link

Overview:
- MCU-facing command/status port for the VCXO discipline loop.
- It is the other end of the loop's control interface: it produces the signed correction the loop consumes, and it returns the loop's frequency error and PWM state to the MCU.
- It also derives a lock flag from the error.
- It sits in the TCXO clock domain, between the MCU byte bus and the VCXO controller.

Parameters:
CORR_LIMIT, 100, magnitude clamp applied to the written correction (0..127)
LOCK_TOL, 20, |freq_error| bound (in 100 Hz units) that counts as in-lock
LOCK_CYCLES, 1228800, consecutive in-tolerance clk cycles needed to assert locked (32-bit counter)

Ports:
clk_in  in  1  TCXO clock; all logic on its rising edge
reset_n_in  in  1  synchronous, active-low reset
freq_error_in  in  24  signed frequency error from the loop
pwm_in  in  24  signed current PWM duty from the loop
cmd_frame_in  in  1  high for the duration of an MCU transaction
cmd_data_in  in  8  MCU byte
cmd_valid_in  in  1  one-cycle strobe, one per MCU byte
resp_data  out  8  response byte
resp_valid  out  1  one-cycle strobe qualifying resp_data
VCXO_correction  out  8  signed correction to the loop
locked  out  1  loop-locked flag
cmd_error  out  1  sticky unknown-opcode flag

Behaviour:
- Reset (reset_n_in low at a clk_in edge): every output is 0 (VCXO_correction, locked, cmd_error, resp_data, resp_valid). State goes to IDLE; status snapshot and lock counter are cleared. Reset mid-transaction aborts it with no partial effects.
- Byte acceptance: a byte is accepted only on a cycle with cmd_valid_in=1 and cmd_frame_in=1. Strobes while the frame is low are ignored.
- Frame end: any cycle with cmd_frame_in=0 forces state to IDLE. This includes a cycle where a strobe coincides with frame fall; that byte is dropped.
- Opcodes, taken from the first accepted byte of a frame:
  - 0xA0 WR_CORR: next byte is the correction.
  - 0xA1 RD_STATUS: 6-byte read.
  - 0xA2 RD_LOCK: 1-byte read.
  - 0xA3 CLR_ERR: clears cmd_error the next cycle.
  - Any other value: sets cmd_error and goes to DRAIN.
- States and transitions:
  - IDLE -> OPCODE on frame high.
  - OPCODE -> WR_CORR / RD_STATUS / RD_LOCK / DRAIN on the opcode byte.
  - WR_CORR -> DRAIN after its data byte.
  - RD_STATUS -> DRAIN after the 6th byte.
  - RD_LOCK -> DRAIN after its 1 byte.
  - DRAIN ignores bytes (no resp_valid) until the frame falls.
- WR_CORR: the data byte is treated as signed and clamped to [-CORR_LIMIT, +CORR_LIMIT]. It drives VCXO_correction on the cycle after the strobe and is held until the next write or reset. A frame dropped before the data byte leaves VCXO_correction unchanged.
- RD_STATUS: freq_error_in and pwm_in are snapshotted on the opcode strobe cycle, so the 6 returned bytes are coherent.
  - The MCU clocks 6 dummy bytes.
  - For the k-th dummy strobe, resp_data/resp_valid appear exactly 1 cycle later.
  - Byte order: freq_error[23:16], [15:8], [7:0], then pwm[23:16], [15:8], [7:0].
- RD_LOCK: the response byte is {6'b0, cmd_error, locked}, sampled at the dummy strobe. Latency is 1 cycle, as for RD_STATUS.
- resp_valid is high for exactly one cycle per returned byte. resp_data holds its last value otherwise.
- Lock detection runs every cycle, independent of the command FSM:
  - A cycle is in tolerance when -LOCK_TOL <= freq_error_in <= LOCK_TOL (signed compare, no abs, so -2^23 is handled).
  - In tolerance: the counter increments, saturating at LOCK_CYCLES. locked=1 from the cycle after the counter reaches LOCK_CYCLES.
  - Out of tolerance: counter=0 and locked=0 on the next cycle.
- cmd_error has priority: if an unknown opcode and 0xA3 occur in different frames, each takes effect in order. It cannot be set and cleared in the same cycle.

Test Plan:
- Reset: drive reset_n_in=0 for 2 cycles with frame active and strobes toggling -> all outputs 0, and the next frame is decoded from OPCODE.
- Write with clamp (CORR_LIMIT=100): frame A0 then 0x7F -> VCXO_correction=100 one cycle after the strobe. Frame A0 then 0x9C (-100) -> -100. Frame A0 then 0x05 -> 5. A frame with only A0 then dropped -> value stays 5.
- Status read: freq_error_in=-3 (0xFFFFFD), pwm_in=250 (0x0000FA). Change both inputs right after the opcode strobe -> returned bytes are FF FF FD 00 00 FA, each resp_valid exactly 1 cycle after its dummy strobe. A 7th dummy byte produces no resp_valid.
- Lock (LOCK_CYCLES=16, LOCK_TOL=20): hold freq_error_in=20 -> locked rises on cycle 17. Set it to 21 -> locked falls the next cycle. Set -20 -> relocks after 16 more cycles.
- Error path: frame 0x55 -> cmd_error=1. Frame A2 + dummy -> response 0x02 (0x03 if locked). Frame A3 -> cmd_error=0.
- Boundary: strobe coincident with frame fall is ignored. A strobe with frame low is ignored. Frame fall mid-RD_STATUS after 2 bytes -> next frame starts cleanly at OPCODE.
